dual_rail_inject_arb: RTL and testbench

DUAL_RAIL_INJECT_ARB -- requirements
Module: dual_rail_inject_arb

---
 rtl/dual_rail_inject_arb.sv | 146 ++++++++++++++
 tb/tb_dual_rail_inject_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_rail_inject_arb.sv
// Two-requester round-robin arbiter that injects words into a dual-rail
// four-phase asynchronous pipeline, with dr_ack synchronizer and watchdog.
module dual_rail_inject_arb #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_data,
    output logic                 req1_ready,
    output logic [2*WIDTH-1:0]   dr_data,
    input  logic                 dr_ack,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_RTZ,
        IDLE,
        DATA,
        NULL,
        ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_grant_q, last_grant_d;
    logic [2*WIDTH-1:0]     dr_data_q, dr_data_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   ack_s;
    logic                   pick1;
    logic                   grant0;
    logic                   grant1;
    logic [WD_W-1:0]        wd_inc;
    logic                   wd_expired;

    // One rail per bit high: true rail carries the bit, false rail its complement.
    function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] w);
        logic [2*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+1] = w[i];
            r[2*i]   = ~w[i];
        end
        return r;
    endfunction

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], dr_ack};
        // last_grant_q=1 means requester 1 was served last, so requester 0 wins a tie.
        pick1      = req1_valid & (~req0_valid | ~last_grant_q);
        grant0     = (state_q == IDLE) & ~rst & req0_valid & ~pick1;
        grant1     = (state_q == IDLE) & ~rst & pick1;
        wd_inc     = wd_q + 1'b1;
        wd_expired = (wd_inc == WD_LAST);
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        dr_data_d     = dr_data_q;
        case (state_q)
            WAIT_RTZ: begin
                if (!ack_s)
                    state_d = IDLE;
                else if (wd_expired)
                    state_d = ERR;
            end
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d      = DATA;
                    last_grant_d = grant1;
                    dr_data_d    = encode(grant1 ? req1_data : req0_data);
                end
            end
            DATA: begin
                if (ack_s) begin
                    state_d   = NULL;
                    dr_data_d = '0;
                end else if (wd_expired) begin
                    state_d   = ERR;
                    dr_data_d = '0;
                end
            end
            NULL: begin
                if (!ack_s)
                    state_d = IDLE;
                else if (wd_expired)
                    state_d = ERR;
            end
            ERR: begin
                dr_data_d = '0;
            end
            default: begin
                state_d   = WAIT_RTZ;
                dr_data_d = '0;
            end
        endcase

        if (state_d != state_q)
            wd_d = '0;
        else if (state_q == WAIT_RTZ || state_q == DATA || state_q == NULL)
            wd_d = wd_inc;
        else
            wd_d = '0;

        timeout_err_d = timeout_err_q | (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_RTZ;
            sync_q        <= '1;
            last_grant_q  <= 1'b1;
            dr_data_q     <= '0;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            last_grant_q  <= last_grant_d;
            dr_data_q     <= dr_data_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign dr_data     = dr_data_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dual_rail_inject_arb.sv
// Directed bench for dual_rail_inject_arb: vector table for arbitration and
// encoding, hand sequences for reset recovery, alternation, mid-NULL reset and timeout.
module tb_dual_rail_inject_arb;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid;
    logic [WIDTH-1:0]   req0_data;
    logic               req0_ready;
    logic               req1_valid;
    logic [WIDTH-1:0]   req1_data;
    logic               req1_ready;
    logic [2*WIDTH-1:0] dr_data;
    logic               dr_ack;
    logic               busy;
    logic               timeout_err;

    logic               stage_en   = 1'b0;
    logic               force_ack  = 1'b0;
    logic [2:0]         hist       = 3'b000;
    logic               checking   = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic             r0v;
        logic [WIDTH-1:0] r0d;
        logic             r1v;
        logic [WIDTH-1:0] r1d;
        logic [1:0]       exp_gnt;
        logic [7:0]       exp_dr;
    } vec_t;

    vec_t vecs[9];

    dual_rail_inject_arb #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .dr_data(dr_data),
        .dr_ack(dr_ack),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Async stage model: ack follows "dr_data holds a code" about three cycles later.
    always @(negedge clk) begin
        hist = {hist[1:0], (dr_data != 8'h00)};
    end
    assign dr_ack = stage_en ? hist[2] : force_ack;

    always @(negedge clk) begin
        logic bad;
        #3;
        if (checking) begin
            bad = 1'b0;
            for (int i = 0; i < WIDTH; i++)
                if ((dr_data[2*i+1] & dr_data[2*i]) === 1'b1) bad = 1'b1;
            if ((req0_ready & req1_ready) === 1'b1) bad = 1'b1;
            n_assert++;
            if (bad) begin
                n_fail++;
                $display("[TB] FAIL protocol at %0t: dr_data=%b req0_ready=%b req1_ready=%b, required no 2'b11 pair and not both ready",
                         $time, dr_data, req0_ready, req1_ready);
            end
        end
    end

    task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] d0,
                                 input logic v1, input logic [WIDTH-1:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitIdle(input string name);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        checkOutput(name, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic runVector(input int idx);
        vec_t v;
        logic seen_spacer;
        logic glitch;
        v = vecs[idx];
        applyStimulus(v.r0v, v.r0d, v.r1v, v.r1d);
        #1;
        checkOutput($sformatf("vec%0d_grant", idx), 32'({req1_ready, req0_ready}), 32'(v.exp_gnt));
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        checkOutput($sformatf("vec%0d_dr_data", idx), 32'(dr_data), 32'(v.exp_dr));
        seen_spacer = 1'b0;
        glitch      = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
            if (dr_data == 8'h00) seen_spacer = 1'b1;
            else if (seen_spacer || dr_data != v.exp_dr) glitch = 1'b1;
        end
        checkOutput($sformatf("vec%0d_idle", idx), 32'(busy), 32'd0);
        checkOutput($sformatf("vec%0d_spacer", idx), 32'({glitch, seen_spacer}), 32'b01);
        @(negedge clk);
    endtask

    initial begin
        int c;
        int ngr;
        int g;
        int rdy_cnt;
        logic bad_data;

        vecs[0] = '{1'b1, 4'hA, 1'b1, 4'h5, 2'b01, 8'b10011001};
        vecs[1] = '{1'b1, 4'h3, 1'b1, 4'hC, 2'b10, 8'b10100101};
        vecs[2] = '{1'b0, 4'h0, 1'b1, 4'hF, 2'b10, 8'b10101010};
        vecs[3] = '{1'b0, 4'h0, 1'b1, 4'h0, 2'b10, 8'b01010101};
        vecs[4] = '{1'b1, 4'h9, 1'b1, 4'h2, 2'b01, 8'b10010110};
        vecs[5] = '{1'b1, 4'hA, 1'b0, 4'h0, 2'b01, 8'b10011001};
        vecs[6] = '{1'b1, 4'h1, 1'b1, 4'hE, 2'b10, 8'b10101001};
        vecs[7] = '{1'b1, 4'h5, 1'b0, 4'h0, 2'b01, 8'b01100110};
        vecs[8] = '{1'b0, 4'h0, 1'b1, 4'h6, 2'b10, 8'b01101001};

        // Reset and release with dr_ack held low.
        rst = 1'b1;
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        checking = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd1);
        checkOutput("reset_dr_data", 32'(dr_data), 32'd0);
        checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
        rst = 1'b0;
        bad_data = 1'b0;
        for (c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (dr_data != 8'h00) bad_data = 1'b1;
            if (!busy) break;
        end
        checkOutput("reset_busy_fall_cycles", 32'(c), 32'(SYNC_STAGES + 1));
        checkOutput("reset_spacer_held", 32'(bad_data), 32'd0);
        @(negedge clk);

        stage_en = 1'b1;
        for (int i = 0; i < 9; i++) runVector(i);

        // Both requesters valid continuously: grants must alternate 0,1,0,1.
        applyStimulus(1'b1, 4'h3, 1'b1, 4'hC);
        ngr = 0;
        for (c = 0; c < 100 && ngr < 4; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                g = req1_ready ? 1 : 0;
                checkOutput($sformatf("alt%0d_grant", ngr), 32'(g), 32'(ngr % 2));
                @(posedge clk);
                #1;
                checkOutput($sformatf("alt%0d_dr_data", ngr), 32'(dr_data),
                            (g == 1) ? 32'b10100101 : 32'b01011010);
                ngr++;
            end
            @(negedge clk);
        end
        checkOutput("alt_grant_count", 32'(ngr), 32'd4);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        waitIdle("alt_idle");

        // Reset while NULL with requester 1 still valid: in-flight word dropped.
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h6);
        #1;
        checkOutput("rnull_grant", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rnull_dr_data", 32'(dr_data), 32'b01101001);
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dr_data == 8'h00) break;
        end
        checkOutput("rnull_reached_null", 32'({busy, (dr_data == 8'h00)}), 32'b11);
        rst = 1'b1;
        req1_data = 4'h9;
        #1;
        checkOutput("rnull_ready_in_rst", 32'({req1_ready, req0_ready}), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rnull_dr_after_rst", 32'(dr_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad_data = 1'b0;
        for (c = 1; c <= 40; c++) begin
            #1;
            if (req1_ready) break;
            if (dr_data != 8'h00) bad_data = 1'b1;
            @(negedge clk);
        end
        checkOutput("rnull_no_resend", 32'(bad_data), 32'd0);
        checkOutput("rnull_late_grant", 32'((c >= SYNC_STAGES + 1) && (c <= 40)), 32'd1);
        checkOutput("rnull_grant_idle", 32'({busy, req1_ready}), 32'b01);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        checkOutput("rnull_new_word", 32'(dr_data), 32'b10010110);
        waitIdle("rnull_idle");

        // Watchdog: dr_ack stuck low in DATA.
        stage_en  = 1'b0;
        force_ack = 1'b0;
        applyStimulus(1'b1, 4'h5, 1'b0, 4'h0);
        #1;
        checkOutput("to_grant", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        checkOutput("to_dr_data", 32'(dr_data), 32'b01100110);
        for (c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (timeout_err) break;
        end
        checkOutput("to_err_cycles", 32'(c), 32'(TIMEOUT - 1));
        checkOutput("to_err_outputs", 32'({busy, timeout_err, dr_data}), 32'({1'b1, 1'b1, 8'h00}));
        @(negedge clk);
        applyStimulus(1'b1, 4'h1, 1'b1, 4'h2);
        rdy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (req0_ready || req1_ready) rdy_cnt++;
            @(negedge clk);
        end
        checkOutput("to_no_grants", 32'(rdy_cnt), 32'd0);
        checkOutput("to_sticky", 32'({timeout_err, dr_data}), 32'({1'b1, 8'h00}));
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("to_rst_clears", 32'({timeout_err, busy}), 32'b01);
        @(negedge clk);
        rst = 1'b0;
        waitIdle("to_recover_idle");

        // Ready must be gated off by rst even from IDLE.
        applyStimulus(1'b1, 4'h4, 1'b0, 4'h0);
        rst = 1'b1;
        #1;
        checkOutput("idle_rst_ready", 32'(req0_ready), 32'd0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
